// File: rtl/boot_sequencer.sv
// ---------------------------------------------------------------------------
// boot_sequencer
//
// Boot controller sitting downstream of the program loader. It asks the
// loader for a program, waits (with a timeout) for the load to finish, then
// takes over the instruction memory port and reads back the first
// SCAN_WORDS words. While reading, it accumulates a balanced-ternary checksum
// modulo 3^WORD_SIZE. Finally it releases the CPU from reset. The CPU is held
// in reset for the whole load/verify sequence. A load timeout parks the
// block in ERROR with the CPU still held.
//
// Trit encoding, two bits per trit, trit i at bits [2i+1:2i]:
//   2'b00 = 0, 2'b01 = +1, 2'b10 = -1  (2'b11 is read as 0)
//
// Ports:
//   clock          rising-edge system clock
//   reset          synchronous, active-high reset
//   boot_request   level, starts a boot from IDLE
//   start_load     one-cycle pulse to the loader
//   load_complete  level from the loader, only looked at while waiting
//   mem_sel        0 = loader owns memory port, 1 = this block owns it
//   mem_addr       ternary read address, held between reads
//   mem_read       read strobe, data returns on mem_read_data next cycle
//   mem_read_data  ternary read data
//   checksum       ternary sum of the scanned words
//   checksum_valid checksum final, held high
//   cpu_reset      active-high hold on the CPU
//   cpu_run        CPU released and running
//   boot_error     load timeout occurred, held high
// ---------------------------------------------------------------------------
module boot_sequencer #(
    parameter int WORD_SIZE     = 9,
    parameter int MEM_ADDR_SIZE = 6,
    parameter int LOAD_TIMEOUT  = 4096,
    parameter int SCAN_WORDS    = 256
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       boot_request,
    output logic                       start_load,
    input  logic                       load_complete,
    output logic                       mem_sel,
    output logic [2*MEM_ADDR_SIZE-1:0] mem_addr,
    output logic                       mem_read,
    input  logic [2*WORD_SIZE-1:0]     mem_read_data,
    output logic [2*WORD_SIZE-1:0]     checksum,
    output logic                       checksum_valid,
    output logic                       cpu_reset,
    output logic                       cpu_run,
    output logic                       boot_error
);

    localparam int WAIT_W = $clog2(LOAD_TIMEOUT);
    localparam int CNT_W  = $clog2(SCAN_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_LOAD, SCAN_REQ, SCAN_ACC, RUN, ERROR
    } state_t;

    state_t                     state_q, state_d;
    logic [WAIT_W-1:0]          waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]           scanCnt_q, scanCnt_d;
    logic [2*MEM_ADDR_SIZE-1:0] scanAddr_q, scanAddr_d;
    logic [2*MEM_ADDR_SIZE-1:0] memAddr_q, memAddr_d;
    logic [2*WORD_SIZE-1:0]     checksum_q, checksum_d;
    logic startLoad_q, startLoad_d;
    logic memSel_q, memSel_d;
    logic memRead_q, memRead_d;
    logic checksumValid_q, checksumValid_d;
    logic cpuReset_q, cpuReset_d;
    logic cpuRun_q, cpuRun_d;
    logic bootError_q, bootError_d;

    function automatic int tritVal(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b10:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] tritEnc(input int v);
        if (v == 1)       return 2'b01;
        else if (v == -1) return 2'b10;
        else              return 2'b00;
    endfunction

    // Ripple-carry balanced-ternary add over WORD_SIZE trits; the final carry
    // is dropped so the result wraps modulo 3^WORD_SIZE.
    function automatic logic [2*WORD_SIZE-1:0] wordAdd(
        input logic [2*WORD_SIZE-1:0] a,
        input logic [2*WORD_SIZE-1:0] b
    );
        logic [2*WORD_SIZE-1:0] s;
        int carry;
        int t;
        s = '0;
        carry = 0;
        for (int i = 0; i < WORD_SIZE; i++) begin
            t = tritVal(a[2*i +: 2]) + tritVal(b[2*i +: 2]) + carry;
            if (t > 1) begin
                t = t - 3;
                carry = 1;
            end else if (t < -1) begin
                t = t + 3;
                carry = -1;
            end else begin
                carry = 0;
            end
            s[2*i +: 2] = tritEnc(t);
        end
        return s;
    endfunction

    // Address + 1 over MEM_ADDR_SIZE trits. This gives the same result as
    // the word adder on a zero-padded address truncated back to address
    // width, so the address wraps from the top of the range to the bottom.
    function automatic logic [2*MEM_ADDR_SIZE-1:0] addrInc(
        input logic [2*MEM_ADDR_SIZE-1:0] a
    );
        logic [2*MEM_ADDR_SIZE-1:0] s;
        int carry;
        int t;
        s = '0;
        carry = 1;
        for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
            t = tritVal(a[2*i +: 2]) + carry;
            if (t > 1) begin
                t = t - 3;
                carry = 1;
            end else begin
                carry = 0;
            end
            s[2*i +: 2] = tritEnc(t);
        end
        return s;
    endfunction

    // State and datapath registers. Every output is a flop loaded from the
    // decode of the next state, so nothing combinational reaches a port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            waitCnt_q       <= '0;
            scanCnt_q       <= '0;
            scanAddr_q      <= '0;
            memAddr_q       <= '0;
            checksum_q      <= '0;
            startLoad_q     <= 1'b0;
            memSel_q        <= 1'b0;
            memRead_q       <= 1'b0;
            checksumValid_q <= 1'b0;
            cpuReset_q      <= 1'b1;
            cpuRun_q        <= 1'b0;
            bootError_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            waitCnt_q       <= waitCnt_d;
            scanCnt_q       <= scanCnt_d;
            scanAddr_q      <= scanAddr_d;
            memAddr_q       <= memAddr_d;
            checksum_q      <= checksum_d;
            startLoad_q     <= startLoad_d;
            memSel_q        <= memSel_d;
            memRead_q       <= memRead_d;
            checksumValid_q <= checksumValid_d;
            cpuReset_q      <= cpuReset_d;
            cpuRun_q        <= cpuRun_d;
            bootError_q     <= bootError_d;
        end
    end

    // Next-state and datapath update. load_complete is checked before the
    // timeout, so a load finishing on the last allowed cycle still wins.
    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        scanCnt_d  = scanCnt_q;
        scanAddr_d = scanAddr_q;
        checksum_d = checksum_q;
        case (state_q)
            IDLE: begin
                if (boot_request) state_d = START;
            end
            START: begin
                waitCnt_d = '0;
                state_d   = WAIT_LOAD;
            end
            WAIT_LOAD: begin
                if (load_complete) begin
                    scanAddr_d = '0;
                    scanCnt_d  = '0;
                    checksum_d = '0;
                    state_d    = SCAN_REQ;
                end else if (waitCnt_q == WAIT_W'(LOAD_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            SCAN_REQ: begin
                state_d = SCAN_ACC;
            end
            SCAN_ACC: begin
                checksum_d = wordAdd(checksum_q, mem_read_data);
                scanAddr_d = addrInc(scanAddr_q);
                if (scanCnt_q == CNT_W'(SCAN_WORDS - 1)) begin
                    state_d = RUN;
                end else begin
                    scanCnt_d = scanCnt_q + CNT_W'(1);
                    state_d   = SCAN_REQ;
                end
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state. mem_addr only moves when a new read
    // is issued, so it holds its last value between reads.
    always_comb begin
        startLoad_d     = (state_d == START);
        memRead_d       = (state_d == SCAN_REQ);
        memSel_d        = (state_d == SCAN_REQ) || (state_d == SCAN_ACC) || (state_d == RUN);
        checksumValid_d = (state_d == RUN);
        cpuRun_d        = (state_d == RUN);
        cpuReset_d      = (state_d != RUN);
        bootError_d     = (state_d == ERROR);
        memAddr_d       = (state_d == SCAN_REQ) ? scanAddr_d : memAddr_q;
    end

    assign start_load     = startLoad_q;
    assign mem_sel        = memSel_q;
    assign mem_addr       = memAddr_q;
    assign mem_read       = memRead_q;
    assign checksum       = checksum_q;
    assign checksum_valid = checksumValid_q;
    assign cpu_reset      = cpuReset_q;
    assign cpu_run        = cpuRun_q;
    assign boot_error     = bootError_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_boot_sequencer
//
// Directed bench for boot_sequencer with 3-trit words, 2-trit addresses,
// SCAN_WORDS=4 and LOAD_TIMEOUT=16. A small memory model answers reads one
// cycle after mem_read. Expected values are hand-computed balanced-ternary
// constants (00=0, 01=+1, 10=-1 per trit, trit 0 in the low bits).
// ---------------------------------------------------------------------------
module tb_boot_sequencer;

    localparam int WS = 3;
    localparam int AS = 2;
    localparam int SW = 4;
    localparam int LT = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            bootRequest = 1'b0;
    logic            loadComplete = 1'b0;
    logic            startLoad;
    logic            memSel;
    logic [2*AS-1:0] memAddr;
    logic            memRead;
    logic [2*WS-1:0] memReadData = '0;
    logic [2*WS-1:0] checksum;
    logic            checksumValid;
    logic            cpuReset;
    logic            cpuRun;
    logic            bootError;

    logic [2*WS-1:0] mem [0:8];
    logic [2*AS-1:0] addrQ [$];
    int              startPulses;
    int              memReads;
    int              numAsserts = 0;
    int              numFails = 0;
    int              steps;

    boot_sequencer #(
        .WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .LOAD_TIMEOUT(LT), .SCAN_WORDS(SW)
    ) dut (
        .clock(clock), .reset(reset), .boot_request(bootRequest),
        .start_load(startLoad), .load_complete(loadComplete),
        .mem_sel(memSel), .mem_addr(memAddr), .mem_read(memRead),
        .mem_read_data(memReadData), .checksum(checksum),
        .checksum_valid(checksumValid), .cpu_reset(cpuReset),
        .cpu_run(cpuRun), .boot_error(bootError)
    );

    always #5 clock = ~clock;

    // Maps a 2-trit address (-4..+4) onto mem[0..8].
    function automatic int addrIdx(input logic [2*AS-1:0] a);
        int v;
        v = 0;
        for (int i = AS - 1; i >= 0; i--) begin
            v = v * 3;
            if (a[2*i +: 2] == 2'b01) v = v + 1;
            else if (a[2*i +: 2] == 2'b10) v = v - 1;
        end
        return v + 4;
    endfunction

    // Memory model: read data appears the cycle after the strobe.
    always @(posedge clock) begin
        if (memRead) memReadData <= mem[addrIdx(memAddr)];
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic done);
        bootRequest  = req;
        loadComplete = done;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numAsserts++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpu_reset"}, 32'(cpuReset), 32'd1);
        checkOutput({tag, "_checksum"}, 32'(checksum), 32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
        checkOutput({tag, "_start_load"}, 32'(startLoad), 32'd0);
        checkOutput({tag, "_mem_read"}, 32'(memRead), 32'd0);
        checkOutput({tag, "_mem_sel"}, 32'(memSel), 32'd0);
        checkOutput({tag, "_valid"}, 32'(checksumValid), 32'd0);
        checkOutput({tag, "_cpu_run"}, 32'(cpuRun), 32'd0);
        checkOutput({tag, "_boot_error"}, 32'(bootError), 32'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    // Drives boot_request for one cycle, raises load_complete once loadAt
    // steps have passed, and steps until RUN, ERROR, stopAt steps or a cap.
    // Step n leaves the bench in the n-th cycle after the boot_request cycle.
    task automatic runBoot(input int loadAt, input int stopAt, output int n);
        addrQ.delete();
        startPulses = 0;
        memReads = 0;
        n = 0;
        applyStimulus(1'b1, 1'b0);
        while (!cpuRun && !bootError && n < 80 && n != stopAt) begin
            if (n == loadAt) loadComplete = 1'b1;
            step();
            n++;
            if (n == 1) bootRequest = 1'b0;
            if (startLoad) startPulses++;
            if (memRead) begin
                memReads++;
                addrQ.push_back(memAddr);
            end
        end
    endtask

    task automatic checkAddrs(input string tag);
        logic [2*AS-1:0] expAddr [4];
        expAddr = '{4'b0000, 4'b0001, 4'b0110, 4'b0100};
        checkOutput({tag, "_nreads"}, 32'(addrQ.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i),
                        32'((i < addrQ.size()) ? addrQ[i] : 4'b1111), 32'(expAddr[i]));
        end
    endtask

    task automatic loadPlusMem();
        for (int i = 0; i < 9; i++) mem[i] = '0;
        mem[4] = 6'b000001;
        mem[5] = 6'b000001;
        mem[6] = 6'b000001;
        mem[7] = 6'b000010;
    endtask

    initial begin
        loadPlusMem();

        // Test 1: reset for three cycles, then ten idle cycles.
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (3) step();
        checkResetValues("reset");
        reset = 1'b0;
        startPulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (startLoad) startPulses++;
        end
        checkResetValues("idle");
        checkOutput("idle_start_pulses", 32'(startPulses), 32'd0);

        // Test 2: words +1,+1,+1,-1; load seen on 5th WAIT_LOAD cycle.
        // cpu_run lands 3+5+8=16 cycles counting the boot_request cycle.
        runBoot(6, -1, steps);
        checkOutput("scan_latency", 32'(steps + 1), 32'd16);
        checkOutput("scan_start_pulses", 32'(startPulses), 32'd1);
        checkOutput("scan_checksum", 32'(checksum), 32'(6'b000110));
        checkOutput("scan_valid", 32'(checksumValid), 32'd1);
        checkOutput("scan_cpu_run", 32'(cpuRun), 32'd1);
        checkOutput("scan_cpu_reset", 32'(cpuReset), 32'd0);
        checkOutput("scan_mem_sel", 32'(memSel), 32'd1);
        checkAddrs("scan");
        applyStimulus(1'b1, 1'b1);
        repeat (3) step();
        checkOutput("run_hold", 32'(cpuRun), 32'd1);
        checkOutput("run_no_read", 32'(memRead), 32'd0);

        // Test 3: no load ever -> ERROR after 16 WAIT_LOAD cycles.
        doReset();
        startPulses = 0;
        memReads = 0;
        applyStimulus(1'b1, 1'b0);
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 1) bootRequest = 1'b0;
            if (memRead) memReads++;
            if (n == 17 || n == 18 || n == 20)
                checkOutput($sformatf("timeout_err_step%0d", n), 32'(bootError), 32'(n >= 18));
        end
        checkOutput("timeout_cpu_reset", 32'(cpuReset), 32'd1);
        checkOutput("timeout_mem_sel", 32'(memSel), 32'd0);
        checkOutput("timeout_cpu_run", 32'(cpuRun), 32'd0);
        checkOutput("timeout_reads", 32'(memReads), 32'd0);

        // Test 5: load_complete arrives on the 16th (last) WAIT_LOAD cycle.
        doReset();
        runBoot(17, 18, steps);
        checkOutput("race_steps", 32'(steps), 32'd18);
        checkOutput("race_mem_read", 32'(memRead), 32'd1);
        checkOutput("race_mem_sel", 32'(memSel), 32'd1);
        checkOutput("race_boot_error", 32'(bootError), 32'd0);

        // Test 4: +13 + +13 + 0 + 0 = 26, which wraps to -1 mod 27.
        doReset();
        mem[4] = 6'b010101;
        mem[5] = 6'b010101;
        mem[6] = 6'b000000;
        mem[7] = 6'b000000;
        runBoot(3, -1, steps);
        checkOutput("wrap_checksum", 32'(checksum), 32'(6'b000010));
        checkOutput("wrap_valid", 32'(checksumValid), 32'd1);

        // Test 6: reset during SCAN_ACC of word 2, then a clean reboot.
        doReset();
        loadPlusMem();
        runBoot(6, 12, steps);
        checkOutput("abort_reads", 32'(addrQ.size()), 32'd3);
        checkOutput("abort_in_acc", 32'(memRead), 32'd0);
        reset = 1'b1;
        step();
        checkResetValues("abort");
        reset = 1'b0;
        runBoot(6, -1, steps);
        checkOutput("reboot_latency", 32'(steps + 1), 32'd16);
        checkOutput("reboot_checksum", 32'(checksum), 32'(6'b000110));
        checkAddrs("reboot");

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
Name: boot_sequencer

Overview:
Top-level boot controller that sits directly downstream of the program loader.
- Requests a program load, then waits for completion with a timeout.
- Takes over the instruction memory port and reads back the first SCAN_WORDS words, accumulating a ternary modular checksum.
- Releases the CPU from reset. The CPU is held in reset for the whole load/verify sequence.

Parameters:
WORD_SIZE, from parameters.vh, trits per memory word (2 bits per trit, codebase trit encoding `_0/`_1/`_1_).
MEM_ADDR_SIZE, from parameters.vh, trits per memory address.
LOAD_TIMEOUT, 4096, max cycles spent in WAIT_LOAD before error; must be >= 2.
SCAN_WORDS, 256, number of words read back and summed; must be >= 1.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
boot_request  input  1  level; starts a boot sequence from IDLE.
start_load  output  1  one-cycle pulse to the loader.
load_complete  input  1  level from the loader; sticky until loader reset.
mem_sel  output  1  0 = loader owns the memory port, 1 = this block owns it.
mem_addr  output  2*MEM_ADDR_SIZE  ternary read address.
mem_read  output  1  read strobe; data returns on mem_read_data the next cycle.
mem_read_data  input  2*WORD_SIZE  ternary read data.
checksum  output  2*WORD_SIZE  ternary sum of the scanned words.
checksum_valid  output  1  checksum final; held high.
cpu_reset  output  1  active-high hold on the CPU.
cpu_run  output  1  CPU released and running.
boot_error  output  1  load timeout occurred; held high.

Behaviour:
- Reset values: cpu_reset=1; checksum all trits `_0; mem_addr all trits `_0. Every other output is 0.
- Reset mid-operation: all state returns to IDLE and reset values on the next edge; start_load and mem_read are deasserted.
- State IDLE: if boot_request=1, go to START.
- State START: start_load=1 for exactly this one cycle. Clear timeout counter. Go to WAIT_LOAD.
- State WAIT_LOAD: load_complete is sampled only in this state.
  - If load_complete=1: mem_sel<=1, scan address<=0, scan count<=0, checksum<=0, go to SCAN_REQ.
  - Else: increment counter; when counter==LOAD_TIMEOUT-1, go to ERROR.
  - If load_complete rises in the same cycle the timeout is reached, load_complete wins.
- State SCAN_REQ: mem_read=1, mem_addr=scan address. Go to SCAN_ACC.
- State SCAN_ACC: mem_read=0 and mem_read_data is valid.
  - checksum <= checksum + mem_read_data via ternary_ripple_carry_adder, WORD_SIZE trits; carry-out discarded, so the sum wraps modulo 3^WORD_SIZE.
  - Scan address <= address + 1 via a ternary adder, padded to WORD_SIZE and truncated to MEM_ADDR_SIZE trits; wraps at the address range.
  - If scan count==SCAN_WORDS-1, go to RUN; else increment the count and go to SCAN_REQ.
  - Throughput: 2 cycles per word; scan takes 2*SCAN_WORDS cycles.
- Scan count is a binary counter of width ceil(log2(SCAN_WORDS+1)).
- State RUN: checksum_valid=1, cpu_reset=0, cpu_run=1, mem_sel=1. Terminal until reset; boot_request is ignored.
- State ERROR: boot_error=1, cpu_reset=1, mem_sel=0, cpu_run=0. Terminal until reset.
- All outputs are registered; no combinational path from input to output.
- mem_addr holds its last value when mem_read=0.
- Latency: boot_request to cpu_run = 3 + W + 2*SCAN_WORDS cycles, where W is the WAIT_LOAD cycles before load_complete is seen.

Test Plan:
1. Reset held 3 cycles, then boot_request=0 for 10 cycles -> cpu_reset=1, start_load never pulses, all other outputs 0.
2. SCAN_WORDS=4, memory words {+1,+1,+1,-1}, load_complete asserted 5 cycles after start_load -> checksum=+2, checksum_valid=1, cpu_run=1 exactly 3+5+8 cycles after boot_request; mem_addr sequence 0,1,2,3.
3. LOAD_TIMEOUT=16, load_complete never asserted -> boot_error=1 after 16 WAIT_LOAD cycles; cpu_reset stays 1; mem_read never asserted.
4. WORD_SIZE wrap: two words each equal to the max positive value (all trits +1), SCAN_WORDS=2 -> checksum equals the modular ternary sum (carry discarded), matching the adder reference model.
5. load_complete rises on the same cycle the timeout is reached -> scan starts, boot_error stays 0.
6. Reset asserted during SCAN_ACC of word 2 -> next cycle all outputs at reset values; new boot_request repeats the scan from address 0 with checksum restarted at 0.
